// File: rtl/cnn_stream_pkg.sv
// rtl/cnn_stream_pkg.sv - shared widths and FSM encoding for the frame streamer
package cnn_stream_pkg;

    localparam int W_SIZE       = 12;
    localparam int W_DELAY      = 12;
    localparam int W_FRAME_SIZE = 2 * W_SIZE + 1;
    localparam int W_DATA       = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STARTUP = 3'd1,
        ST_LINE    = 3'd2,
        ST_HBLANK  = 3'd3,
        ST_DONE    = 3'd4
    } stream_state_t;

endpackage

// File: rtl/cnn_stream_delay_cnt.sv
// rtl/cnn_stream_delay_cnt.sv - loadable down-counter with zero flag for blanking intervals
module cnn_stream_delay_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cnn_frame_streamer.sv
// rtl/cnn_frame_streamer.sv - raster pixel source reading a frame buffer with start-up and hsync blanking
module cnn_frame_streamer
    import cnn_stream_pkg::*;
#(
    parameter int W_SIZE       = cnn_stream_pkg::W_SIZE,
    parameter int W_DELAY      = cnn_stream_pkg::W_DELAY,
    parameter int W_FRAME_SIZE = cnn_stream_pkg::W_FRAME_SIZE,
    parameter int W_DATA       = cnn_stream_pkg::W_DATA
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    i_start,
    input  logic [W_SIZE-1:0]       i_width,
    input  logic [W_SIZE-1:0]       i_height,
    input  logic [W_DELAY-1:0]      i_start_up_delay,
    input  logic [W_DELAY-1:0]      i_hsync_delay,
    input  logic [W_FRAME_SIZE-1:0] i_base_addr,
    output logic                    o_rd_en,
    output logic [W_FRAME_SIZE-1:0] o_rd_addr,
    input  logic [W_DATA-1:0]       i_rd_data,
    output logic [W_DATA-1:0]       o_pixel,
    output logic                    o_valid,
    output logic [W_SIZE-1:0]       o_row,
    output logic [W_SIZE-1:0]       o_col,
    output logic                    o_line_end,
    output logic                    o_frame_done,
    output logic                    o_busy
);

    stream_state_t state, state_next;

    logic [W_SIZE-1:0]       width_m1;
    logic [W_SIZE-1:0]       height_m1;
    logic                    empty;
    logic [W_DELAY-1:0]      hsync;
    logic [W_SIZE-1:0]       col;
    logic [W_SIZE-1:0]       row;
    logic [W_FRAME_SIZE-1:0] addr;

    logic                    cnt_load;
    logic [W_DELAY-1:0]      cnt_val;
    logic                    cnt_dec;
    logic [W_DELAY-1:0]      cnt_count;
    logic                    cnt_zero;

    logic                    rd_en;
    logic                    accept;
    logic                    col_last;
    logic                    row_last;

    // The counter holds (delay-1) so a blanking interval of N lasts exactly N cycles.
    cnn_stream_delay_cnt #(.W(W_DELAY)) u_delay_cnt (
        .clk      (HCLK),
        .resetn   (HRESETn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    assign accept   = (state == ST_IDLE) && i_start;
    assign col_last = (col == width_m1);
    assign row_last = (row == height_m1);

    always_comb begin
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_dec      = 1'b0;
        rd_en        = 1'b0;
        o_frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_STARTUP;
                    cnt_load   = 1'b1;
                    cnt_val    = (i_start_up_delay == '0) ? '0 : i_start_up_delay - W_DELAY'(1);
                end
            end
            ST_STARTUP: begin
                if (cnt_zero) begin
                    state_next = empty ? ST_DONE : ST_LINE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_LINE: begin
                rd_en = 1'b1;
                if (col_last) begin
                    if (row_last) begin
                        state_next = ST_DONE;
                    end else if (hsync == '0) begin
                        state_next = ST_LINE;
                    end else begin
                        state_next = ST_HBLANK;
                        cnt_load   = 1'b1;
                        cnt_val    = hsync - W_DELAY'(1);
                    end
                end
            end
            ST_HBLANK: begin
                if (cnt_zero) begin
                    state_next = ST_LINE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                // Wait for the last read's data to leave the output stage before signalling.
                if (!o_valid) begin
                    o_frame_done = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            width_m1  <= '0;
            height_m1 <= '0;
            empty     <= 1'b0;
            hsync     <= '0;
            col       <= '0;
            row       <= '0;
            addr      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                width_m1  <= i_width - W_SIZE'(1);
                height_m1 <= i_height - W_SIZE'(1);
                empty     <= (i_width == '0) || (i_height == '0);
                hsync     <= i_hsync_delay;
                col       <= '0;
                row       <= '0;
                addr      <= i_base_addr;
            end else if (rd_en) begin
                addr <= addr + W_FRAME_SIZE'(1);
                if (col_last) begin
                    col <= '0;
                    row <= row + W_SIZE'(1);
                end else begin
                    col <= col + W_SIZE'(1);
                end
            end
        end
    end

    // Output stage: one-cycle image of the read strobe, aligned with the buffer's read data.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            o_valid    <= 1'b0;
            o_row      <= '0;
            o_col      <= '0;
            o_line_end <= 1'b0;
        end else begin
            o_valid    <= rd_en;
            o_row      <= rd_en ? row : '0;
            o_col      <= rd_en ? col : '0;
            o_line_end <= rd_en && col_last;
        end
    end

    assign o_rd_en   = rd_en;
    assign o_rd_addr = addr;
    assign o_pixel   = o_valid ? i_rd_data : '0;
    assign o_busy    = (state != ST_IDLE);

endmodule
